// File: rtl/flags_gen.sv
// Condition-flag producer: computes {N,Z,C,V} from the EX-stage ALU result and
// commits it through a one-entry pending stage. `define FLAGS_BYPASS_EN forwards the pending entry.
module flags_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [1:0]       op_i,
  input  logic [2:0]       cond_i,
  input  logic [1:0]       alu_ctrl_i,
  input  logic             set_flags_i,
  input  logic             cond_ex_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [3:0]       flags_o,
  output logic             stall_req_o
);

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  logic       sa, sb, sr;
  logic [3:0] calc_f;
  logic       cap;

  logic       pend_v_d, pend_v_q;
  logic [3:0] pend_f_d, pend_f_q;
  logic [3:0] arch_f_d, arch_f_q;

  assign sa = a_i[WIDTH-1];
  assign sb = b_i[WIDTH-1];
  assign sr = result_i[WIDTH-1];

  always_comb begin
    calc_f    = 4'b0000;
    calc_f[3] = sr;
    calc_f[2] = (result_i == '0);
    case (alu_ctrl_i)
      ALU_ADD: begin
        calc_f[1] = carry_i;
        calc_f[0] = ~(sa ^ sb) & (sa ^ sr);
      end
      ALU_SUB: begin
        calc_f[1] = carry_i;
        calc_f[0] = (sa ^ sb) & (sa ^ sr);
      end
      default: ;  // logical ops clear C and V
    endcase
  end

  assign cap = valid_i & (op_i == OP_DP) & set_flags_i & cond_ex_i & ~stall_i & ~flush_i;

  // Flush only suppresses the new capture; an older pending entry still retires.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_f_d = pend_f_q;
    arch_f_d = arch_f_q;
    if (!stall_i) begin
      if (pend_v_q) arch_f_d = pend_f_q;
      pend_v_d = cap;
      if (cap) pend_f_d = calc_f;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_v_q <= 1'b0;
      pend_f_q <= 4'b0000;
      arch_f_q <= 4'b0000;
    end else begin
      pend_v_q <= pend_v_d;
      pend_f_q <= pend_f_d;
      arch_f_q <= arch_f_d;
    end
  end

`ifdef FLAGS_BYPASS_EN
  assign flags_o     = pend_v_q ? pend_f_q : arch_f_q;
  assign stall_req_o = 1'b0;
`else
  assign flags_o     = arch_f_q;
  assign stall_req_o = pend_v_q & valid_i & (op_i == OP_BR) & (cond_i != 3'b000);
`endif

endmodule

// File: tb/tb_flags_gen.sv
// Directed-vector bench for flags_gen; expectations adapt to FLAGS_BYPASS_EN.
module tb_flags_gen;

`ifdef FLAGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, set_flags_i, cond_ex_i, carry_i, stall_i, flush_i;
  logic [1:0]  op_i, alu_ctrl_i;
  logic [2:0]  cond_i;
  logic [31:0] a_i, b_i, result_i;
  logic [3:0]  flags_o;
  logic        stall_req_o;

  int n_chk  = 0;
  int n_pass = 0;

  flags_gen #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .cond_i(cond_i),
    .alu_ctrl_i(alu_ctrl_i), .set_flags_i(set_flags_i), .cond_ex_i(cond_ex_i),
    .a_i(a_i), .b_i(b_i), .result_i(result_i), .carry_i(carry_i),
    .stall_i(stall_i), .flush_i(flush_i), .flags_o(flags_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; op_i = 2'b00; cond_i = 3'b000; alu_ctrl_i = 2'b00;
    set_flags_i = 0; cond_ex_i = 0; a_i = 0; b_i = 0; result_i = 0;
    carry_i = 0; stall_i = 0; flush_i = 0;
  endtask

  // SUB 5-5: Z and C (no borrow) -> 0110
  task automatic sub_eq(input logic cex);
    idle();
    valid_i = 1; alu_ctrl_i = 2'b01; set_flags_i = 1; cond_ex_i = cex;
    a_i = 32'd5; b_i = 32'd5; result_i = 32'd0; carry_i = 1;
  endtask

  // ADD 0x7FFFFFFF+1: N and V -> 1001
  task automatic add_ovf();
    idle();
    valid_i = 1; alu_ctrl_i = 2'b00; set_flags_i = 1; cond_ex_i = 1;
    a_i = 32'h7FFF_FFFF; b_i = 32'd1; result_i = 32'h8000_0000; carry_i = 0;
  endtask

  // AND with negative result, carry_i set to prove C is forced 0 -> 1000
  task automatic and_neg();
    idle();
    valid_i = 1; alu_ctrl_i = 2'b10; set_flags_i = 1; cond_ex_i = 1;
    a_i = 32'hFFFF_FFFF; b_i = 32'h8000_0000; result_i = 32'h8000_0000; carry_i = 1;
  endtask

  task automatic branch(input logic [2:0] c);
    idle();
    valid_i = 1; op_i = 2'b10; cond_i = c;
  endtask

  initial begin
    // 1: reset with random inputs
    idle();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      {valid_i, set_flags_i, cond_ex_i, carry_i} = 4'($urandom);
      op_i = 2'($urandom); cond_i = 3'($urandom); alu_ctrl_i = 2'($urandom);
      a_i = $urandom; b_i = $urandom; result_i = $urandom;
      tick();
      chk("rst_flags", flags_o, 4'b0000);
      chk("rst_stall", {3'b0, stall_req_o}, 4'b0000);
    end
    idle();
    reset = 1;
    tick(); tick();
    chk("post_rst", flags_o, 4'b0000);

    // 2: SUB equal
    sub_eq(1); tick(); idle();
    chk("sub_1edge", flags_o, BYP ? 4'b0110 : 4'b0000);
    tick();
    chk("sub_2edge", flags_o, 4'b0110);

    // 3: ADD overflow, then a cond_ex=0 setter that must not update
    add_ovf(); tick(); idle();
    chk("add_1edge", flags_o, BYP ? 4'b1001 : 4'b0110);
    tick();
    chk("add_2edge", flags_o, 4'b1001);
    sub_eq(0); tick(); idle(); tick();
    chk("condex0", flags_o, 4'b1001);

    // 4: back-to-back SUB then AND
    sub_eq(1); tick();
    and_neg(); tick(); idle();
    chk("b2b_first", flags_o, BYP ? 4'b1000 : 4'b0110);
    tick();
    chk("b2b_second", flags_o, 4'b1000);

    // 4b: same with a 3-cycle stall between
    sub_eq(1); tick();
    and_neg(); stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", flags_o, BYP ? 4'b0110 : 4'b1000);
    end
    stall_i = 0; tick(); idle();
    chk("stall_rel1", flags_o, BYP ? 4'b1000 : 4'b0110);
    tick();
    chk("stall_rel2", flags_o, 4'b1000);

    // 5: flushed capture is dropped
    sub_eq(1); flush_i = 1; tick(); idle(); tick();
    chk("flush_drop", flags_o, 4'b1000);
    // flush with an older pending entry: the older one still commits
    add_ovf(); tick();
    sub_eq(1); flush_i = 1; tick(); idle();
    chk("flush_old1", flags_o, 4'b1001);
    tick();
    chk("flush_old2", flags_o, 4'b1001);

    // 6: flag hazard on a conditional branch
    sub_eq(1); tick();
    branch(3'b001); #1;
    chk("haz_req", {3'b0, stall_req_o}, BYP ? 4'b0000 : 4'b0001);
    tick();
    chk("haz_clear", {3'b0, stall_req_o}, 4'b0000);
    chk("haz_flags", flags_o, 4'b0110);
    add_ovf(); tick();
    branch(3'b000); #1;
    chk("haz_always", {3'b0, stall_req_o}, 4'b0000);
    tick(); idle();

    // reset mid-update discards the pending entry
    and_neg(); tick();
    reset = 0; #1;
    chk("rst_mid", flags_o, 4'b0000);
    idle(); tick();
    reset = 1; tick(); tick();
    chk("rst_mid_after", flags_o, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
